fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter D_WIDTH, default 32, SHALL set the width of every address, immediate and instruction bus.
REQ-002: Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003: CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004: rst  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005: imem_req_valid  output  1  SHALL flag a fetch request to instruction memory.
REQ-006: imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-007: imem_addr  output  D_WIDTH  SHALL carry the fetch address, equal to the current PC.
REQ-008: imem_rsp_valid  input  1  SHALL flag that the instruction word for the accepted request is present.
REQ-009: imem_rsp_data  input  D_WIDTH  SHALL carry the returned instruction word.
REQ-010: instr_valid  output  1  SHALL flag that a fetched instruction is offered downstream.
REQ-011: instr_ready  input  1  SHALL flag that downstream consumes the offered instruction.
REQ-012: instr, instr_pc  output  D_WIDTH each  SHALL carry the offered instruction and its address.
REQ-013: redirect  input  1  SHALL request a PC change to branch_pc + branch_imm.
REQ-014: branch_pc, branch_imm  input  D_WIDTH each  SHALL carry the branch base address and the sign-extended offset.
REQ-015: misalign_err  output  1  SHALL flag a rejected misaligned redirect (see REQ-032).

Function
REQ-016: The redirect target SHALL be branch_pc + branch_imm, modulo 2^D_WIDTH, with no overflow flag.
REQ-017: The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and DRAIN.
REQ-018: At most one memory request SHALL be outstanding, and the memory SHALL return responses in order.
REQ-019: imem_req_valid SHALL be 1 only in REQ; instr_valid SHALL be 1 only in HOLD.
REQ-020: IDLE SHALL go to REQ unconditionally on the next edge.
REQ-021: In REQ with imem_req_ready=1 and redirect=0, the FSM SHALL go to WAIT and the PC SHALL hold.
REQ-022: In REQ with redirect=1 and imem_req_ready=0, the PC SHALL load the target and the FSM SHALL stay in REQ; requests are non-sticky, so the address may change while imem_req_ready=0.
REQ-023: In REQ with redirect=1 and imem_req_ready=1, the request SHALL be accepted at the old PC, the PC SHALL load the target, and the FSM SHALL go to DRAIN.
REQ-024: In WAIT with imem_rsp_valid=1 and redirect=0:
- instr SHALL latch imem_rsp_data;
- instr_pc SHALL latch the PC;
- the PC SHALL advance to PC+4;
- the FSM SHALL go to HOLD.
REQ-025: In WAIT with redirect=1 and imem_rsp_valid=0, the PC SHALL load the target and the FSM SHALL go to DRAIN.
REQ-026: In WAIT with redirect=1 and imem_rsp_valid=1, the response SHALL be discarded, the PC SHALL load the target, and the FSM SHALL go to REQ.
REQ-027: In DRAIN, the first imem_rsp_valid SHALL be discarded and the FSM SHALL go to REQ; a redirect in DRAIN SHALL update the PC and keep the FSM in DRAIN.
REQ-028: In HOLD, instr and instr_pc SHALL stay stable until a handshake; instr_ready=1 SHALL move the FSM to REQ.
REQ-029: In HOLD with redirect=1, the held instruction SHALL be dropped whatever instr_ready is (redirect has priority), the PC SHALL load the target, and the FSM SHALL go to REQ.
REQ-030: Latency SHALL be as follows:
- request accept to instr_valid is 1 cycle after imem_rsp_valid;
- peak throughput with zero-wait memory is one instruction per 3 cycles.

Reset
REQ-031: While rst=0, the block SHALL hold these values:
- state = IDLE;
- PC = RESET_PC;
- imem_req_valid = 0, instr_valid = 0;
- instr = 0, instr_pc = 0;
- misalign_err = 0.
A response arriving during reset or in the IDLE state SHALL be ignored.

Configuration
REQ-032: Macro FETCH_MISALIGN_CHECK_EN SHALL control misaligned-target handling:
- Defined: a redirect whose target[1:0] != 0 SHALL be ignored entirely (PC and state unchanged) and SHALL set misalign_err sticky until reset.
- Undefined: target[1:0] SHALL be forced to 0 and misalign_err SHALL be tied to 0.

Verification
REQ-033: Reset release, RESET_PC=0x100, memory ready with 0-wait response 0x00500093 -> instr_valid with instr=0x00500093 and instr_pc=0x100; the next imem_addr is 0x104.
REQ-034: HOLD with instr_ready=0 for 5 cycles -> instr and instr_pc stable, no new request; instr_ready=1 -> REQ with imem_addr=PC+4.
REQ-035: Redirect in WAIT (branch_pc=0x200, branch_imm=-8) with the response 2 cycles later -> response dropped, no instr_valid, next imem_addr=0x1F8.
REQ-036: Redirect and imem_req_ready in the same REQ cycle -> old address accepted, DRAIN entered, its response discarded, next request at the target.
REQ-037: Redirect target 0x102 -> with the macro: ignored and misalign_err=1 held; without the macro: imem_addr=0x100 and misalign_err=0.
REQ-038: rst asserted in WAIT with the response pending -> outputs at reset values immediately; after release the first request goes to RESET_PC and the stale response is ignored in IDLE.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect handling, single-entry output hold.
// Optional build macro FETCH_MISALIGN_CHECK_EN: reject misaligned redirect targets and flag misalign_err.
//
// state | meaning
// IDLE  | first cycle after reset, responses ignored
// REQ   | imem_req_valid asserted at PC
// WAIT  | request accepted, awaiting its response
// HOLD  | instruction offered downstream
// DRAIN | accepted request made stale by a redirect, discard its response
module fetch_sequencer #(
  parameter int                 D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [D_WIDTH-1:0] instr,
  output logic [D_WIDTH-1:0] instr_pc,
  input  logic               redirect,
  input  logic [D_WIDTH-1:0] branch_pc,
  input  logic [D_WIDTH-1:0] branch_imm,
  output logic               misalign_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t             state;
  logic [D_WIDTH-1:0] pc;
  logic [D_WIDTH-1:0] target_sum;
  logic [D_WIDTH-1:0] target;
  logic               redir;

  assign target_sum = branch_pc + branch_imm;
  assign imem_addr  = pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;

  assign target     = target_sum;
  assign misaligned = redirect && (target_sum[1:0] != 2'b00);
  assign redir      = redirect && !misaligned;

  // Sticky until reset; IDLE ignores redirects entirely so it does not flag either.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
    end else if (state != S_IDLE && misaligned) begin
      misalign_err <= 1'b1;
    end
  end
`else
  localparam logic [D_WIDTH-1:0] ALIGN_MASK = ~(D_WIDTH'(3));

  assign target       = target_sum & ALIGN_MASK;
  assign redir        = redirect;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (redir) begin
            pc <= target;
            // Accepted at the old PC: its response must still be drained.
            if (imem_req_ready) begin
              state          <= S_DRAIN;
              imem_req_valid <= 1'b0;
            end
          end else if (imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redir) begin
            pc <= target;
            if (imem_rsp_valid) begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            pc          <= pc + D_WIDTH'(4);
            state       <= S_HOLD;
            instr_valid <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (redir) pc <= target;
          // A redirect arriving with the stale response must not strand the FSM here.
          if (imem_rsp_valid) begin
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redir || instr_ready) begin
            if (redir) pc <= target;
            state          <= S_REQ;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level reference model plus reactive memory, directed then random.
module tb_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h100;

  logic        CLK = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] branch_pc, branch_imm;
  logic        misalign_err;

  fetch_sequencer #(.D_WIDTH(32), .RESET_PC(RPC)) dut (
    .CLK(CLK), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .branch_pc(branch_pc), .branch_imm(branch_imm),
    .misalign_err(misalign_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: fetch bookkeeping in transaction terms.
  logic        m_idle, m_pending, m_stale, m_hold, m_err;
  logic [31:0] m_pc, m_instr, m_ipc, m_req_addr;

  // Memory: one outstanding request, answered after mem_lat cycles.
  logic        mem_armed;
  int          mem_cnt, mem_lat;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (~a ^ 32'h1357_9BDF);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_pending = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_err = 1'b0;
    m_pc = RPC; m_instr = '0; m_ipc = '0; m_req_addr = '0;
  endtask

  task automatic model_edge();
    logic [31:0] sum, tgt;
    logic        eff;
    if (!rst) begin
      model_reset();
      return;
    end
    sum = branch_pc + branch_imm;
`ifdef FETCH_MISALIGN_CHECK_EN
    eff = redirect && (sum[1:0] == 2'b00);
    tgt = sum;
    if (!m_idle && redirect && sum[1:0] != 2'b00) m_err = 1'b1;
`else
    eff = redirect;
    tgt = {sum[31:2], 2'b00};
`endif
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_hold) begin
      if (eff) begin m_hold = 1'b0; m_pc = tgt; end
      else if (instr_ready) m_hold = 1'b0;
    end else if (m_pending) begin
      if (imem_rsp_valid) begin
        m_pending = 1'b0;
        if (!m_stale && !eff) begin
          m_hold = 1'b1; m_instr = imem_rsp_data; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
      end
      if (eff) begin m_pc = tgt; m_stale = 1'b1; end
    end else if (imem_req_ready) begin
      m_pending = 1'b1; m_stale = eff; m_req_addr = m_pc;
      if (eff) m_pc = tgt;
    end else if (eff) begin
      m_pc = tgt;
    end
  endtask

  task automatic compare();
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, !m_idle && !m_pending && !m_hold});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  task automatic drive_mem();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!m_pending) begin
      mem_armed = 1'b0;
    end else begin
      if (!mem_armed) begin mem_armed = 1'b1; mem_cnt = mem_lat; end
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(m_req_addr);
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
    drive_mem();
  endtask

  initial begin
    logic seen_iv;
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect = 1'b0; branch_pc = '0; branch_imm = '0;
    mem_armed = 1'b0; mem_cnt = 0; mem_lat = 0;
    model_reset();
    repeat (3) step();

    // Reset release, zero-wait fetch at RESET_PC.
    rst = 1'b1; imem_req_ready = 1'b1; mem_lat = 0;
    chk("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("idle_addr", imem_addr, 32'h100);
    step();
    chk("first_req", {31'b0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h100);
    step();
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);
    chk("hold_instr", instr, 32'h00500093);
    chk("hold_pc", instr_pc, 32'h100);
    chk("next_addr", imem_addr, 32'h104);

    // Back-pressure in HOLD.
    repeat (5) begin
      step();
      chk("stall_instr", instr, 32'h00500093);
      chk("stall_pc", instr_pc, 32'h100);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("after_hs_req", {31'b0, imem_req_valid}, 32'd1);
    chk("after_hs_addr", imem_addr, 32'h104);

    // Redirect while waiting, response two cycles later is dropped.
    mem_lat = 2;
    step();
    redirect = 1'b1; branch_pc = 32'h200; branch_imm = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("drain_addr", imem_addr, 32'h1F8);
    seen_iv = 1'b0;
    for (int i = 0; i < 8 && !imem_req_valid; i++) begin step(); seen_iv |= instr_valid; end
    chk("wait_redir_req", {31'b0, imem_req_valid}, 32'd1);
    chk("wait_redir_addr", imem_addr, 32'h1F8);
    chk("wait_redir_drop", {31'b0, seen_iv}, 32'd0);

    // Redirect coincident with acceptance: old address goes out, then target.
    mem_lat = 1;
    redirect = 1'b1; branch_pc = 32'h300; branch_imm = 32'h10;
    step();
    redirect = 1'b0;
    chk("req_redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    chk("req_redir_pc", imem_addr, 32'h310);
    seen_iv = 1'b0;
    for (int i = 0; i < 8 && !imem_req_valid; i++) begin step(); seen_iv |= instr_valid; end
    chk("req_redir_req", {31'b0, imem_req_valid}, 32'd1);
    chk("req_redir_addr", imem_addr, 32'h310);
    chk("req_redir_drop", {31'b0, seen_iv}, 32'd0);

    // Misaligned target 0x102.
    imem_req_ready = 1'b0;
    redirect = 1'b1; branch_pc = 32'h100; branch_imm = 32'h2;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_addr", imem_addr, 32'h310);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    step();
    chk("mis_err_sticky", {31'b0, misalign_err}, 32'd1);
`else
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_err", {31'b0, misalign_err}, 32'd0);
`endif

    // Reset during WAIT with a response pending, stale response in IDLE.
    imem_req_ready = 1'b1; mem_lat = 3;
    step();
    step();
    chk("pre_rst_wait", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_err", {31'b0, misalign_err}, 32'd0);
    step();
    rst = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    chk("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h100);
    mem_lat = 0;
    step();
    step();
    chk("post_rst_instr", instr, 32'h00500093);
    chk("post_rst_valid", {31'b0, instr_valid}, 32'd1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      instr_ready    = ($urandom_range(0, 1) == 1);
      redirect       = ($urandom_range(0, 9) == 0);
      branch_pc      = $urandom & 32'hFFFF_FFFC;
      branch_imm     = ($urandom_range(0, 255) * 4) - 512;
      if ($urandom_range(0, 3) == 0) branch_imm = branch_imm + $urandom_range(1, 3);
      mem_lat        = $urandom_range(0, 3);
      rst            = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
